// File: rtl/gate_pkg.sv
// Shared encodings for the parking-gate sensor decoder: FSM states and sensor-pair codes.
package gate_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN1   = 3'd1,
    EN2   = 3'd2,
    EN3   = 3'd3,
    EX1   = 3'd4,
    EX2   = 3'd5,
    EX3   = 3'd6,
    FAULT = 3'd7
  } state_e;

  // Sensor pair {outer, inner}, 1 = beam blocked
  localparam logic [1:0] AB_CLEAR = 2'b00;
  localparam logic [1:0] AB_OUTER = 2'b10;
  localparam logic [1:0] AB_BOTH  = 2'b11;
  localparam logic [1:0] AB_INNER = 2'b01;

endpackage

// File: rtl/sensor_sync.sv
// Per-sensor synchronizer; with GATE_DEBOUNCE_EN defined a stability filter follows it.
module sensor_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("sensor_sync: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  // Synchronizer shift chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], din};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GATE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // Filter only follows a value that has differed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_sync != r_filt) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_filt <= w_sync;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign dout = r_filt;
`else
  assign dout = w_sync;
`endif

endmodule

// File: rtl/gate_sensor_decoder.sv
// Parking-gate decoder: turns outer/inner photo-sensor passes into up/down count pulses.
// Optional input debouncing is enabled by defining GATE_DEBOUNCE_EN.
module gate_sensor_decoder
  import gate_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic up,
  output logic down,
  output logic busy,
  output logic fault
);

  logic       w_sa;
  logic       w_sb;
  logic [1:0] w_ab;
  state_e     r_state;
  state_e     w_next;
  logic       w_up;
  logic       w_down;
  logic       r_up;
  logic       r_down;
  logic       r_busy;
  logic       r_fault;

  sensor_sync #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_a (
    .clk(clk), .reset(reset), .din(a), .dout(w_sa)
  );

  sensor_sync #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_b (
    .clk(clk), .reset(reset), .din(b), .dout(w_sb)
  );

  assign w_ab = {w_sa, w_sb};

  // Next-state and pulse decode; unlisted sensor pairs hold the state
  always_comb begin
    w_next = r_state;
    w_up   = 1'b0;
    w_down = 1'b0;
    case (r_state)
      IDLE: begin
        case (w_ab)
          AB_OUTER: w_next = EN1;
          AB_INNER: w_next = EX1;
          AB_BOTH:  w_next = FAULT;
          default:  w_next = IDLE;
        endcase
      end
      EN1: begin
        case (w_ab)
          AB_BOTH:  w_next = EN2;
          AB_CLEAR: w_next = IDLE;
          AB_INNER: w_next = FAULT;
          default:  w_next = EN1;
        endcase
      end
      EN2: begin
        case (w_ab)
          AB_INNER: w_next = EN3;
          AB_OUTER: w_next = EN1;
          AB_CLEAR: w_next = FAULT;
          default:  w_next = EN2;
        endcase
      end
      EN3: begin
        case (w_ab)
          AB_CLEAR: begin
            w_next = IDLE;
            w_up   = 1'b1;
          end
          AB_BOTH:  w_next = EN2;
          AB_OUTER: w_next = FAULT;
          default:  w_next = EN3;
        endcase
      end
      EX1: begin
        case (w_ab)
          AB_BOTH:  w_next = EX2;
          AB_CLEAR: w_next = IDLE;
          AB_OUTER: w_next = FAULT;
          default:  w_next = EX1;
        endcase
      end
      EX2: begin
        case (w_ab)
          AB_OUTER: w_next = EX3;
          AB_INNER: w_next = EX1;
          AB_CLEAR: w_next = FAULT;
          default:  w_next = EX2;
        endcase
      end
      EX3: begin
        case (w_ab)
          AB_CLEAR: begin
            w_next = IDLE;
            w_down = 1'b1;
          end
          AB_BOTH:  w_next = EX2;
          AB_INNER: w_next = FAULT;
          default:  w_next = EX3;
        endcase
      end
      FAULT: begin
        if (w_ab == AB_CLEAR) w_next = IDLE;
        else                  w_next = FAULT;
      end
      default: w_next = FAULT;
    endcase
  end

  // State and outputs share one edge so pulses and flags line up with the state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_up    <= w_up;
      r_down  <= w_down;
      r_busy  <= (w_next != IDLE);
      r_fault <= (w_next == FAULT);
    end
  end

  assign up    = r_up;
  assign down  = r_down;
  assign busy  = r_busy;
  assign fault = r_fault;

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Table-driven bench for gate_sensor_decoder plus hand-written latency and reset sequences.
module tb_gate_sensor_decoder;

`ifdef GATE_DEBOUNCE_EN
  localparam int LAT  = 7;
  localparam int HOLD = 12;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 5;
`endif

  logic clk = 1'b0;
  logic reset;
  logic a;
  logic b;
  logic up;
  logic down;
  logic busy;
  logic fault;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic a;
    logic b;
    int   ups;
    int   downs;
    logic busy;
    logic fault;
  } vec_t;

  vec_t vecs[$];

  gate_sensor_decoder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .up(up), .down(down), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic va, input logic vb, input int u, input int d,
                              input logic bs, input logic fl);
    vec_t v;
    v.a = va; v.b = vb; v.ups = u; v.downs = d; v.busy = bs; v.fault = fl;
    return v;
  endfunction

  // Drive a sensor pair for n cycles, counting pulses and checking exclusivity
  task automatic apply(input logic va, input logic vb, input int n, output int ups, output int downs);
    ups = 0;
    downs = 0;
    a = va;
    b = vb;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ups   += int'(up);
      downs += int'(down);
      chk("up_down_exclusive", int'(up & down), 0);
    end
  endtask

  initial begin
    int u;
    int d;
    int k;

    // entry
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    // exit
    vecs.push_back(mk(1'b0, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 0, 1, 1'b0, 1'b0));
    // aborted entry
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0));
    // reversal then completion
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    // illegal both-blocked from idle, recovery, then a normal entry
    vecs.push_back(mk(1'b1, 1'b1, 0, 0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 0, 0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    // illegal mid-exit: EX1 sees 10
    vecs.push_back(mk(1'b0, 1'b1, 0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0));

    reset = 1'b0;
    a = 1'b0;
    b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_up", int'(up), 0);
    chk("reset_down", int'(down), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fault", int'(fault), 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].a, vecs[i].b, HOLD, u, d);
      chk($sformatf("vec%0d_ups", i), u, vecs[i].ups);
      chk($sformatf("vec%0d_downs", i), d, vecs[i].downs);
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_fault", i), int'(fault), int'(vecs[i].fault));
    end

    // Exact pulse latency and width after the final clear
    apply(1'b1, 1'b0, HOLD, u, d);
    apply(1'b1, 1'b1, HOLD, u, d);
    apply(1'b0, 1'b1, HOLD, u, d);
    a = 1'b0;
    b = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_up_edge%0d", e), int'(up), (e == LAT) ? 1 : 0);
      chk($sformatf("lat_busy_edge%0d", e), int'(busy), (e < LAT) ? 1 : 0);
    end
    apply(1'b0, 1'b0, HOLD, u, d);

    // Reset while in EN2 clears outputs without a clock, then held 11 is illegal
    apply(1'b1, 1'b0, HOLD, u, d);
    apply(1'b1, 1'b1, HOLD, u, d);
    chk("en2_busy", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_outputs", int'({up, down, busy, fault}), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    k = 0;
    while (!fault && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      chk("post_reset_no_up", int'(up), 0);
    end
    chk("post_reset_fault", int'(fault), 1);
    chk("post_reset_fault_edges", k, LAT);
    apply(1'b0, 1'b1, HOLD, u, d);
    chk("post_reset_fault_hold", int'(fault), 1);
    apply(1'b0, 1'b0, HOLD, u, d);
    chk("post_reset_clear_ups", u + d, 0);
    chk("post_reset_clear_fault", int'(fault), 0);

`ifdef GATE_DEBOUNCE_EN
    // A 2-cycle glitch is filtered; a held change reaches the FSM after LAT edges
    apply(1'b1, 1'b0, 2, u, d);
    apply(1'b0, 1'b0, HOLD, u, d);
    chk("glitch_busy", int'(busy), 0);
    a = 1'b1;
    k = 0;
    while (!busy && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("debounce_en1_edges", k, LAT);
    apply(1'b0, 1'b0, HOLD, u, d);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sensor_decoder.md
Name: gate_sensor_decoder

Overview:
- Decodes the two parking-gate photo-sensors into single-cycle enter/exit event pulses.
- Sensor `a` is outer (street side); sensor `b` is inner (lot side).
- Directly drives the `up`/`down` inputs of the lot occupancy counter: `up` for a car entering, `down` for a car exiting.
- Rejects aborted passes, reversals and illegal sensor patterns; never issues simultaneous `up`/`down`.

Parameters:
- SYNC_STAGES, 2, flip-flop stages per sensor synchronizer (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a filtered sensor changes; only used with GATE_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  1  raw outer sensor, asynchronous, 1 = beam blocked.
- b  input  1  raw inner sensor, asynchronous, 1 = beam blocked.
- up  output  1  one-cycle pulse on each completed entry.
- down  output  1  one-cycle pulse on each completed exit.
- busy  output  1  high while the FSM is not in IDLE.
- fault  output  1  high while the FSM is in FAULT.

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchronizer flops clear to 0.
  - FSM goes to IDLE.
  - `up`, `down`, `busy` and `fault` are all 0.
  - Reset mid-sequence discards the partial pass; no pulse is generated.
- Input path:
  - `a` and `b` each pass through a SYNC_STAGES-deep synchronizer, giving `sa` and `sb`.
  - The FSM acts on the pair `ab = {sa,sb}`.
- FSM states and transitions (any pair not listed holds the current state):
  - IDLE: 10 -> EN1; 01 -> EX1; 11 -> FAULT.
  - EN1: 11 -> EN2; 00 -> IDLE (abort); 01 -> FAULT.
  - EN2: 01 -> EN3; 10 -> EN1 (backing out); 00 -> FAULT.
  - EN3: 00 -> IDLE and pulse `up`; 11 -> EN2; 10 -> FAULT.
  - EX1: 11 -> EX2; 00 -> IDLE (abort); 10 -> FAULT.
  - EX2: 10 -> EX3; 01 -> EX1; 00 -> FAULT.
  - EX3: 00 -> IDLE and pulse `down`; 11 -> EX2; 01 -> FAULT.
  - FAULT: holds until 00, then -> IDLE. No pulse is ever generated on leaving FAULT.
- Output timing:
  - `up` and `down` are registered and change on the same edge as the transition into IDLE.
  - Each pulse is exactly 1 cycle wide and deasserts on the next edge.
  - `up` and `down` are never high in the same cycle.
- Latency: a raw-input change reaches the outputs after SYNC_STAGES+1 rising edges (3 at default, debounce off).
- `busy` and `fault` are registered decodes of the state register.
- Back-to-back cars: a new 10 in the cycle after returning to IDLE starts a fresh entry normally.
- A sensor pair that is stable for any length of time holds the current state indefinitely; there is no timeout.

Optional Feature:
- Macro: GATE_DEBOUNCE_EN.
- Defined:
  - Each synchronized sensor feeds a debounce filter.
  - The filtered value takes the new synchronized value only after it has differed from the filtered value for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - The counter is $clog2(DEBOUNCE_CYCLES+1) bits wide and resets to 0; the filtered output resets to 0.
  - Added latency is DEBOUNCE_CYCLES cycles.
- Undefined: the synchronized values drive the FSM directly and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Shared package/include `gate_pkg`: state encoding constants (IDLE, EN1-EN3, EX1-EX3, FAULT as 3-bit localparams) and the sensor-pair constants 2'b00, 2'b10, 2'b11, 2'b01.
- Sub-module `sensor_sync`:
  - Contains the SYNC_STAGES synchronizer plus the debounce filter under GATE_DEBOUNCE_EN.
  - Instantiated once per sensor.
  - Ports: clk, reset, din, dout.

Test Plan:
- Entry 00->10->11->01->00, each step held 5 cycles -> exactly one `up` pulse 3 edges after the final 00; `down` stays 0; `busy` is 1 from EN1 until the pulse edge.
- Exit 00->01->11->10->00 -> exactly one `down` pulse; `up` stays 0.
- Aborted entry 00->10->00, and reversal 10->11->10->11->01->00 -> no pulse for the abort; exactly one `up` for the reversal sequence.
- Illegal 00->11 -> `fault`=1 within 3 edges and holds through 11->01; on 00, `fault` drops with no pulse, and a following entry yields one `up`.
- Assert reset while in EN2 (ab=11) -> all outputs 0 immediately without waiting for a clock; after release with ab held at 11 -> FSM enters FAULT, not EN3.
- GATE_DEBOUNCE_EN with DEBOUNCE_CYCLES=4: a 2-cycle glitch on `a` while in IDLE -> no state change; `a` held for 6 cycles -> EN1 entered 4+3 edges after the change.
